mem_arb_2p: RTL and testbench
=============================

Name: mem_arb_2p

Overview:
Parametrised single-port synchronous RAM shared by two independent requestors, A and B, through per-port valid/ready handshakes. A round-robin arbiter accepts at most one transaction per cycle. It is the successor to the single-requestor handshake memory, adding byte enables, a configurable pipelined read latency and out-of-range error reporting. It sits between two bus masters (e.g. DMA and CPU) and local storage.

Parameters:
WIDTH, 16, data width in bits; must be a multiple of 8.
DEPTH, 64, number of words; need not be a power of two.
ADDR_WIDTH, $clog2(DEPTH), address width.
BE_WIDTH, WIDTH/8, byte-enable width.
RD_LATENCY, 1, cycles from read accept to rvalid; legal range 1..4.

Ports:
clk  in  1  clock; all logic is on posedge.
rst  in  1  synchronous reset, active-low.
valid_a  in  1  port A request valid.
ready_a  out  1  port A request accepted this cycle.
wt_rd_a  in  1  port A 1=write, 0=read.
addr_a  in  ADDR_WIDTH  port A word address.
wdata_a  in  WIDTH  port A write data.
be_a  in  BE_WIDTH  port A byte enables; bit i covers byte [8i+7:8i].
rdata_a  out  WIDTH  port A read data.
rvalid_a  out  1  port A read data valid pulse.
err_a  out  1  port A out-of-range error pulse.
valid_b, ready_b, wt_rd_b, addr_b, wdata_b, be_b, rdata_b, rvalid_b, err_b: identical to the port A signals, for port B.

Behaviour:
- Reset (rst==0 at posedge):
  - ready_a and ready_b are forced 0 combinationally while rst==0.
  - rvalid_x, err_x and rdata_x are cleared to 0.
  - The read pipeline is flushed, so in-flight reads produce no response.
  - The priority pointer is set to A.
  - RAM contents are retained across reset and are undefined at power-up.
- Handshake:
  - A transaction is accepted on a posedge where valid_x && ready_x.
  - ready_x is combinational from the valid signals and the pointer.
  - The requestor holds valid, wt_rd, addr, wdata and be stable until accepted. valid may drop only after acceptance.
  - No response-side backpressure: every response is delivered.
- Arbitration:
  - Only one valid asserted: that port gets ready.
  - Both valid: the port selected by the pointer gets ready.
  - After any accepted transaction, the pointer moves to the other port.
  - Sustained contention therefore alternates A, B, A, B.
  - Throughput: one accepted transaction per cycle total.
- Write:
  - On the accept edge, bytes whose be bit is 1 are written to addr; other bytes are unchanged.
  - be all-zero is a legal no-op write.
  - Writes produce no rvalid.
- Read:
  - rdata_x carries the word at addr, with rvalid_x high for exactly one cycle, RD_LATENCY cycles after the accept edge.
  - Reads are fully pipelined: back-to-back accepts give back-to-back rvalid pulses.
  - rdata_x holds its last value between pulses.
  - Responses return only to the issuing port, in order per port.
- Ordering:
  - A write commits on its accept edge.
  - A read accepted on any later cycle, from either port, returns the new data.
- Out-of-range (addr >= DEPTH):
  - The transaction is still accepted.
  - A write leaves the RAM unchanged and pulses err_x one cycle after accept.
  - A read returns rdata_x=0, with err_x and rvalid_x asserted together RD_LATENCY cycles after accept.
- Simultaneous responses:
  - rvalid_a and rvalid_b may be high in the same cycle for reads accepted on different cycles when the pipeline aligns them. Both are delivered.
- Reset mid-operation:
  - Pending reads are dropped.
  - Any write already accepted has been committed.

Test Plan:
1. Reset, then via A write addr 0..63 with be=2'b11 and random data; read all 64 addresses via B -> every rdata_b matches, rvalid_b rises exactly 1 cycle after each accept, ready_a never low while valid_a is alone.
2. Write 16'hABCD to addr 5 with be=2'b11, then 16'h3412 to addr 5 with be=2'b01, then read -> rdata=16'hAB12.
3. Hold valid_a and valid_b high for 8 cycles (A writing, B reading) -> accepts go A, B, A, B, ... with A first after reset, and exactly one ready high per cycle.
4. DEPTH=48: read addr 50 via B -> rdata_b=0 with err_b=1 and rvalid_b=1 in the same cycle; write addr 47 then addr 50 -> addr 47 intact, err pulse only for addr 50.
5. RD_LATENCY=3: four back-to-back reads of addrs 1..4 via A -> four consecutive rvalid_a pulses starting 3 cycles after the first accept, data in order.
6. Issue a read with RD_LATENCY=3, then drive rst=0 one cycle after accept -> no rvalid and all outputs 0; after rst=1, reading previously written addresses returns the original data.

Source files
------------

// File: rtl/mem_arb_2p.sv
// rtl/mem_arb_2p.sv - two requestors sharing one synchronous RAM through a round-robin arbiter
// Byte-enable writes, RD_LATENCY-deep read pipeline, out-of-range error pulses.
module mem_arb_2p #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BE_WIDTH   = WIDTH / 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_a,
  output logic                  ready_a,
  input  logic                  wt_rd_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [WIDTH-1:0]      wdata_a,
  input  logic [BE_WIDTH-1:0]   be_a,
  output logic [WIDTH-1:0]      rdata_a,
  output logic                  rvalid_a,
  output logic                  err_a,
  input  logic                  valid_b,
  output logic                  ready_b,
  input  logic                  wt_rd_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [WIDTH-1:0]      wdata_b,
  input  logic [BE_WIDTH-1:0]   be_b,
  output logic [WIDTH-1:0]      rdata_b,
  output logic                  rvalid_b,
  output logic                  err_b
);

  localparam int                  LP_LAST  = RD_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = DEPTH[ADDR_WIDTH:0];

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic                  r_ptr_b;
  logic                  r_werr_a;
  logic                  r_werr_b;
  logic [WIDTH-1:0]      r_hold_a;
  logic [WIDTH-1:0]      r_hold_b;
  logic [RD_LATENCY-1:0] r_pv;
  logic [RD_LATENCY-1:0] r_pport;
  logic [RD_LATENCY-1:0] r_perr;
  logic [WIDTH-1:0]      r_pdata [RD_LATENCY];

  logic                  w_acc;
  logic                  w_sel_b;
  logic                  w_wr;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WIDTH-1:0]      w_wdata;
  logic [BE_WIDTH-1:0]   w_be;
  logic [WIDTH-1:0]      w_rd_word;
  logic                  w_out_v;
  logic                  w_out_b;

  // r_ptr_b marks B as the preferred port when both request
  always_comb begin
    ready_a = rst && valid_a && (!valid_b || !r_ptr_b);
    ready_b = rst && valid_b && (!valid_a || r_ptr_b);
  end

  always_comb begin
    w_sel_b    = ready_b;
    w_acc      = ready_a || ready_b;
    w_wr       = w_sel_b ? wt_rd_b : wt_rd_a;
    w_addr     = w_sel_b ? addr_b  : addr_a;
    w_wdata    = w_sel_b ? wdata_b : wdata_a;
    w_be       = w_sel_b ? be_b    : be_a;
    w_in_range = {1'b0, w_addr} < LP_DEPTH;
    w_rd_word  = w_in_range ? r_mem[w_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (w_acc && w_wr && w_in_range) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (w_be[i]) r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= w_acc && !w_wr;
      for (int i = 1; i < RD_LATENCY; i++) r_pv[i] <= r_pv[i-1];
    end
  end

  // Payload stages need no reset: they are only observed behind r_pv
  always_ff @(posedge clk) begin
    r_pport[0] <= w_sel_b;
    r_perr[0]  <= !w_in_range;
    r_pdata[0] <= w_rd_word;
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_pport[i] <= r_pport[i-1];
      r_perr[i]  <= r_perr[i-1];
      r_pdata[i] <= r_pdata[i-1];
    end
  end

  always_comb begin
    w_out_v  = r_pv[LP_LAST];
    w_out_b  = r_pport[LP_LAST];
    rvalid_a = w_out_v && !w_out_b;
    rvalid_b = w_out_v && w_out_b;
    err_a    = r_werr_a || (rvalid_a && r_perr[LP_LAST]);
    err_b    = r_werr_b || (rvalid_b && r_perr[LP_LAST]);
    rdata_a  = rvalid_a ? r_pdata[LP_LAST] : r_hold_a;
    rdata_b  = rvalid_b ? r_pdata[LP_LAST] : r_hold_b;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr_b  <= 1'b0;
      r_werr_a <= 1'b0;
      r_werr_b <= 1'b0;
      r_hold_a <= '0;
      r_hold_b <= '0;
    end else begin
      if (w_acc) r_ptr_b <= !w_sel_b;
      r_werr_a <= w_acc && !w_sel_b && w_wr && !w_in_range;
      r_werr_b <= w_acc && w_sel_b && w_wr && !w_in_range;
      r_hold_a <= rdata_a;
      r_hold_b <= rdata_b;
    end
  end

endmodule

// File: tb/tb_mem_arb_2p.sv
// tb/tb_mem_arb_2p.sv - randomized bench for mem_arb_2p against a queue/array reference model
// Two instances (DEPTH 64/latency 1, DEPTH 48/latency 3) share identical stimulus.
module tb_mem_arb_2p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_a, wt_rd_a, valid_b, wt_rd_b;
  logic [5:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic [1:0]  be_a, be_b;

  logic        ready_a0, ready_b0, rvalid_a0, rvalid_b0, err_a0, err_b0;
  logic        ready_a1, ready_b1, rvalid_a1, rvalid_b1, err_a1, err_b1;
  logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;

  mem_arb_2p #(.WIDTH(16), .DEPTH(64), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .valid_a(valid_a), .ready_a(ready_a0), .wt_rd_a(wt_rd_a), .addr_a(addr_a),
    .wdata_a(wdata_a), .be_a(be_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0), .err_a(err_a0),
    .valid_b(valid_b), .ready_b(ready_b0), .wt_rd_b(wt_rd_b), .addr_b(addr_b),
    .wdata_b(wdata_b), .be_b(be_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0), .err_b(err_b0)
  );

  mem_arb_2p #(.WIDTH(16), .DEPTH(48), .RD_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .valid_a(valid_a), .ready_a(ready_a1), .wt_rd_a(wt_rd_a), .addr_a(addr_a),
    .wdata_a(wdata_a), .be_a(be_a), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1), .err_a(err_a1),
    .valid_b(valid_b), .ready_b(ready_b1), .wt_rd_b(wt_rd_b), .addr_b(addr_b),
    .wdata_b(wdata_b), .be_b(be_b), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1), .err_b(err_b1)
  );

  // Index k = 2*dut + port (port 0 = A, 1 = B)
  logic        o_rdy [4];
  logic        o_rv  [4];
  logic        o_er  [4];
  logic [15:0] o_rd  [4];
  assign o_rdy[0] = ready_a0;  assign o_rdy[1] = ready_b0;
  assign o_rdy[2] = ready_a1;  assign o_rdy[3] = ready_b1;
  assign o_rv[0]  = rvalid_a0; assign o_rv[1]  = rvalid_b0;
  assign o_rv[2]  = rvalid_a1; assign o_rv[3]  = rvalid_b1;
  assign o_er[0]  = err_a0;    assign o_er[1]  = err_b0;
  assign o_er[2]  = err_a1;    assign o_er[3]  = err_b1;
  assign o_rd[0]  = rdata_a0;  assign o_rd[1]  = rdata_b0;
  assign o_rd[2]  = rdata_a1;  assign o_rd[3]  = rdata_b1;

  typedef struct {
    bit        wr;
    bit [5:0]  addr;
    bit [15:0] wdata;
    bit [1:0]  be;
  } req_t;

  req_t        q_a[$];
  req_t        q_b[$];
  int unsigned depth_m [2] = '{64, 48};
  int unsigned lat_m   [2] = '{1, 3};
  bit   [15:0] mem_m   [2][64];
  bit          s_rv    [4][8];
  bit          s_er    [4][8];
  bit   [15:0] s_dat   [4][8];
  bit   [15:0] hold_m  [4];
  bit          last_b;
  bit          rst_drv;
  int          cyc;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Record the architectural effect of an accepted request; cyc is the accept edge index
  function automatic void apply(input int d, input int p, input req_t r);
    int k;
    int slot;
    bit inr;
    k   = d * 2 + p;
    inr = r.addr < depth_m[d];
    if (r.wr) begin
      if (inr) begin
        for (int i = 0; i < 2; i++)
          if (r.be[i]) mem_m[d][r.addr][8*i +: 8] = r.wdata[8*i +: 8];
      end else begin
        s_er[k][cyc % 8] = 1'b1;
      end
    end else begin
      slot           = (cyc + lat_m[d] - 1) % 8;
      s_rv[k][slot]  = 1'b1;
      s_dat[k][slot] = inr ? mem_m[d][r.addr] : 16'h0;
      if (!inr) s_er[k][slot] = 1'b1;
    end
  endfunction

  task automatic cycle();
    int   slot;
    bit   ga, gb;
    req_t r;
    @(negedge clk);
    slot = cyc % 8;
    for (int k = 0; k < 4; k++) begin
      if (s_rv[k][slot]) hold_m[k] = s_dat[k][slot];
      check($sformatf("rvalid k%0d c%0d", k, cyc), o_rv[k], s_rv[k][slot]);
      check($sformatf("err k%0d c%0d", k, cyc), o_er[k], s_er[k][slot]);
      check($sformatf("rdata k%0d c%0d", k, cyc), o_rd[k], hold_m[k]);
      s_rv[k][slot] = 1'b0;
      s_er[k][slot] = 1'b0;
    end
    rst = rst_drv;
    if (q_a.size() > 0) begin
      valid_a = 1'b1; wt_rd_a = q_a[0].wr; addr_a = q_a[0].addr;
      wdata_a = q_a[0].wdata; be_a = q_a[0].be;
    end else begin
      valid_a = 1'b0; wt_rd_a = 1'($urandom); addr_a = 6'($urandom);
      wdata_a = 16'($urandom); be_a = 2'($urandom);
    end
    if (q_b.size() > 0) begin
      valid_b = 1'b1; wt_rd_b = q_b[0].wr; addr_b = q_b[0].addr;
      wdata_b = q_b[0].wdata; be_b = q_b[0].be;
    end else begin
      valid_b = 1'b0; wt_rd_b = 1'($urandom); addr_b = 6'($urandom);
      wdata_b = 16'($urandom); be_b = 2'($urandom);
    end
    ga = rst && valid_a && (!valid_b || last_b);
    gb = rst && valid_b && (!valid_a || !last_b);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("ready_a d%0d c%0d", d, cyc), o_rdy[2*d], ga);
      check($sformatf("ready_b d%0d c%0d", d, cyc), o_rdy[2*d+1], gb);
    end
    @(posedge clk);
    cyc++;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        hold_m[k] = 16'h0;
        for (int s = 0; s < 8; s++) begin
          s_rv[k][s] = 1'b0;
          s_er[k][s] = 1'b0;
        end
      end
      last_b = 1'b1;
    end else if (ga) begin
      r = q_a.pop_front();
      apply(0, 0, r); apply(1, 0, r);
      last_b = 1'b0;
    end else if (gb) begin
      r = q_b.pop_front();
      apply(0, 1, r); apply(1, 1, r);
      last_b = 1'b1;
    end
  endtask

  task automatic push(input bit to_b, input bit wr, input int addr, input int data, input int be);
    req_t r;
    r.wr = wr; r.addr = 6'(addr); r.wdata = 16'(data); r.be = 2'(be);
    if (to_b) q_b.push_back(r);
    else      q_a.push_back(r);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q_a.size() + q_b.size()) > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_pending", q_a.size() + q_b.size(), 0);
    repeat (5) cycle();
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    repeat (2) cycle();
    rst_drv = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b0; rst_drv = 1'b0; last_b = 1'b1; cyc = 0;
    n_checks = 0; n_pass = 0;
    valid_a = 1'b0; valid_b = 1'b0; wt_rd_a = 1'b0; wt_rd_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0; be_a = '0; be_b = '0;

    // Fill memory via A while still in reset so ready must stay low under valid
    for (int i = 0; i < 64; i++) push(1'b0, 1'b1, i, int'($urandom), 3);
    do_reset();
    drain(200);
    for (int i = 0; i < 64; i++) push(1'b1, 1'b0, i, 0, 0);
    drain(200);

    push(1'b0, 1'b1, 5, 16'hABCD, 3);
    push(1'b0, 1'b1, 5, 16'h3412, 1);
    push(1'b0, 1'b0, 5, 0, 0);
    drain(50);
    check("merge_d0", o_rd[0], 16'hAB12);
    check("merge_d1", o_rd[2], 16'hAB12);

    // Contention straight after reset: A must win first, then strict alternation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 1'b1, 8 + i, int'($urandom), 3);
      push(1'b1, 1'b0, 20 + i, 0, 0);
    end
    drain(60);

    push(1'b1, 1'b0, 50, 0, 0);
    push(1'b0, 1'b1, 47, 16'h5A5A, 3);
    push(1'b0, 1'b1, 50, 16'hFFFF, 3);
    push(1'b1, 1'b0, 47, 0, 0);
    drain(50);

    for (int i = 1; i <= 4; i++) push(1'b0, 1'b0, i, 0, 0);
    drain(50);

    // Reset one edge after a read accept: the latency-3 response must vanish
    push(1'b0, 1'b0, 7, 0, 0);
    n = 0;
    while (q_a.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    check("rst_read_accepted", q_a.size(), 0);
    do_reset();
    repeat (4) cycle();
    for (int i = 1; i <= 4; i++) push(1'b1, 1'b0, i, 0, 0);
    drain(50);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4 && q_a.size() < 2)
        push(1'b0, 1'($urandom), int'($urandom_range(0, 63)), int'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) < 4 && q_b.size() < 2)
        push(1'b1, 1'($urandom), int'($urandom_range(0, 63)), int'($urandom), int'($urandom_range(0, 3)));
      cycle();
    end
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
